// File: rtl/hazard_control_unit.sv
// Hazard and forwarding controller for the five-stage pipeline.
// It makes the operand forward selects, handles load-use stalls and
// taken-branch flushes, and holds the front of the pipeline while a
// multi-cycle multiply or divide occupies the execute stage.
module hazard_control_unit #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       LoadE,
  input  logic       PCSrcE,
  input  logic       MulDivStartE,
  input  logic       MulDivOpE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulDivBusy,
  output logic       MulDivDone
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  // The start cycle and the final BUSY cycle (counter == 0) are both stall
  // cycles, so the counter is preloaded with L - 2.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 2);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic lw_stall;
  logic mc_stall;

  // Operand select: the younger memory-stage result beats writeback, and
  // x0 is hard-wired zero so it is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (we_m && (rd_m == rs)) begin
        sel = FWD_MEM;
      end else if (we_w && (rd_w == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  // Forward selects for both execute-stage operands.
  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Hazard detection and the combined stall/flush outputs.
  always_comb begin
    lw_stall   = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // The start cycle stalls immediately, before the FSM leaves IDLE.
    mc_stall   = ((state_q == IDLE) && MulDivStartE) || (state_q == BUSY);
    // A taken branch discards the younger instructions, so holding them is pointless.
    StallF     = (lw_stall || mc_stall) && !PCSrcE;
    StallD     = (lw_stall || mc_stall) && !PCSrcE;
    StallE     = mc_stall;
    FlushD     = PCSrcE;
    FlushE     = PCSrcE || lw_stall;
    // Bubble into memory while execute is held so nothing is retired twice.
    FlushM     = mc_stall;
    MulDivBusy = mc_stall;
    MulDivDone = (state_q == DONE);
  end

  // Multi-cycle sequencer: latches the latency at start, counts down in BUSY,
  // then spends one DONE cycle releasing the stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MulDivStartE) begin
            state_q <= BUSY;
            cnt_q   <= MulDivOpE ? DIV_LOAD : MUL_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with hand-computed expectations.
// Control outputs are packed as {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulDivBusy,MulDivDone}.
module tb_hazard_control_unit;

  logic       clock;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivStartE, MulDivOpE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MulDivBusy, MulDivDone;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] C_IDLE  = 8'h00;
  localparam logic [7:0] C_MC    = 8'hE6; // StallF StallD StallE FlushM Busy
  localparam logic [7:0] C_DONE  = 8'h01;
  localparam logic [7:0] C_LW    = 8'hC8; // StallF StallD FlushE
  localparam logic [7:0] C_BR    = 8'h18; // FlushD FlushE

  hazard_control_unit dut (
    .clock        (clock),
    .reset        (reset),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .LoadE        (LoadE),
    .PCSrcE       (PCSrcE),
    .MulDivStartE (MulDivStartE),
    .MulDivOpE    (MulDivOpE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .MulDivBusy   (MulDivBusy),
    .MulDivDone   (MulDivDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ctrl();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy, MulDivDone};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic expect_cycle(input string tag, input logic [7:0] exp);
    @(negedge clock);
    check(tag, ctrl(), exp);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
    MulDivStartE = 0; MulDivOpE = 0;
  endtask

  task automatic run_mul(input string tag);
    MulDivStartE = 1; MulDivOpE = 0;
    expect_cycle({tag, "_start"}, C_MC);
    MulDivStartE = 0;
    expect_cycle({tag, "_busy1"}, C_MC);
    expect_cycle({tag, "_busy2"}, C_MC);
    expect_cycle({tag, "_done"}, C_DONE);
    expect_cycle({tag, "_idle"}, C_IDLE);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    expect_cycle("reset_quiet", C_IDLE);

    // Forwarding priority
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
    @(negedge clock);
    check("fwdA_mem", {6'd0, ForwardAE}, 8'h02);
    check("fwdB_x0",  {6'd0, ForwardBE}, 8'h00);
    RegWriteM = 0;
    #1;
    check("fwdA_wb", {6'd0, ForwardAE}, 8'h01);
    Rs2E = 5;
    #1;
    check("fwdB_wb", {6'd0, ForwardBE}, 8'h01);
    RdW = 0; Rs1E = 0;
    #1;
    check("fwdA_none", {6'd0, ForwardAE}, 8'h00);
    RegWriteM = 1; RdM = 9; Rs2E = 9; RegWriteW = 0;
    #1;
    check("fwdB_mem", {6'd0, ForwardBE}, 8'h02);
    clear_inputs();
    @(posedge clock);
    #1;

    // Load-use
    LoadE = 1; RdE = 7; Rs2D = 7;
    expect_cycle("lw_rs2", C_LW);
    clear_inputs();
    expect_cycle("lw_released", C_IDLE);
    LoadE = 1; RdE = 4; Rs1D = 4;
    expect_cycle("lw_rs1", C_LW);
    LoadE = 1; RdE = 0; Rs1D = 0;
    expect_cycle("lw_x0", C_IDLE);
    LoadE = 1; RdE = 6; Rs1D = 2; Rs2D = 3;
    expect_cycle("lw_nomatch", C_IDLE);
    clear_inputs();

    // Branch vs load-use
    LoadE = 1; RdE = 3; Rs1D = 3; PCSrcE = 1;
    expect_cycle("br_over_lw", C_BR);
    clear_inputs();
    PCSrcE = 1;
    expect_cycle("br_only", C_BR);
    clear_inputs();

    // Multiply latency
    run_mul("mul");

    // Divide with op flipped during BUSY
    MulDivStartE = 1; MulDivOpE = 1;
    expect_cycle("div_start", C_MC);
    MulDivStartE = 0; MulDivOpE = 0;
    for (int i = 1; i < 8; i++) expect_cycle($sformatf("div_busy%0d", i), C_MC);
    expect_cycle("div_done", C_DONE);
    expect_cycle("div_idle", C_IDLE);

    // Back-to-back with start held through DONE
    MulDivStartE = 1; MulDivOpE = 0;
    expect_cycle("b2b_a_start", C_MC);
    expect_cycle("b2b_a_busy1", C_MC);
    expect_cycle("b2b_a_busy2", C_MC);
    expect_cycle("b2b_a_done", C_DONE);
    expect_cycle("b2b_b_start", C_MC);
    MulDivStartE = 0;
    expect_cycle("b2b_b_busy1", C_MC);
    expect_cycle("b2b_b_busy2", C_MC);
    expect_cycle("b2b_b_done", C_DONE);
    expect_cycle("b2b_idle", C_IDLE);

    // Reset in the fourth BUSY cycle of a divide
    MulDivStartE = 1; MulDivOpE = 1;
    expect_cycle("rdiv_start", C_MC);
    MulDivStartE = 0;
    for (int i = 1; i < 4; i++) expect_cycle($sformatf("rdiv_busy%0d", i), C_MC);
    reset = 1;
    expect_cycle("rdiv_busy4", C_MC);
    reset = 0;
    expect_cycle("rdiv_after_reset", C_IDLE);
    run_mul("post_reset_mul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Hazard and forwarding controller that produces the stall, flush and forward-select signals driving the fetch/decode and decode/execute pipeline registers.
- Consumes register identifiers from the decode, execute, memory and writeback stages.
- Detects RAW forwarding cases, load-use hazards and taken-branch flushes.
- Sequences a multi-cycle stall for multiply/divide operations resident in the execute stage, using an internal FSM and down-counter.

Parameters:
MUL_LATENCY, 3, total execute-stage cycles for a multiply (must be >= 2)
DIV_LATENCY, 8, total execute-stage cycles for a divide (must be >= 2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Rs1D, Rs2D  input  5 each  source registers in decode
Rs1E, Rs2E, RdE  input  5 each  source/destination registers in execute
RdM, RdW  input  5 each  destination registers in memory/writeback
RegWriteM, RegWriteW  input  1 each  write enables in memory/writeback
LoadE  input  1  execute-stage instruction is a load
PCSrcE  input  1  taken branch/jump resolved in execute
MulDivStartE  input  1  multi-cycle multiply/divide in execute
MulDivOpE  input  1  0 = multiply, 1 = divide
StallF, StallD, StallE  output  1 each  hold the fetch, decode and execute stages
FlushD, FlushE, FlushM  output  1 each  clear the F/D, D/E and E/M registers
ForwardAE, ForwardBE  output  2 each  operand select: 00 register file, 01 writeback result, 10 memory ALU result
MulDivBusy  output  1  multi-cycle sequence active
MulDivDone  output  1  one-cycle pulse when the result is final

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset: state <= IDLE, counter <= 0. All outputs are combinational from state and inputs, so with quiescent inputs every output is 0 in the cycle after reset.
- Forwarding (combinational), evaluated separately for ForwardAE (Rs1E) and ForwardBE (Rs2E):
  - 10 if RegWriteM and RdM == RsxE and RsxE != 0.
  - Else 01 if RegWriteW and RdW == RsxE and RsxE != 0.
  - Else 00.
  - Memory takes priority over writeback. x0 is never forwarded.
- Load-use hazard:
  - lwStall = LoadE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
  - Drives StallF = StallD = 1 and FlushE = 1 for that cycle.
- Taken branch: PCSrcE drives FlushD = FlushE = 1. PCSrcE has priority over lwStall: when both are set, StallF and StallD are 0.
- Multi-cycle FSM, states IDLE, BUSY, DONE. L = MUL_LATENCY when MulDivOpE = 0, else DIV_LATENCY. Counter width is clog2(max latency).
  - IDLE:
    - If MulDivStartE: same cycle asserts StallF, StallD, StallE, FlushM and MulDivBusy. Next state BUSY, counter <= L - 2.
    - Else stay in IDLE.
  - BUSY:
    - Asserts StallF, StallD, StallE, FlushM, MulDivBusy.
    - If counter == 0, next state DONE; else counter decrements.
    - MulDivOpE and MulDivStartE are ignored; the latency was latched at start.
  - DONE:
    - MulDivDone = 1. All multi-cycle stalls are released, and the instruction leaves execute at the end of this cycle.
    - MulDivStartE is ignored. Next state IDLE.
  - Totals: exactly L stalled cycles (start cycle + L - 1 BUSY cycles), then one DONE cycle.
  - A back-to-back multiply/divide is accepted in the following IDLE cycle.
- Output combination: StallF and StallD = lwStall-or-multicycle, masked by PCSrcE. PCSrcE cannot occur while BUSY because a mul/div is not a branch. lwStall cannot coexist with MulDivStartE because LoadE and MulDivStartE are exclusive by decoder contract.
- Reset mid-sequence: from BUSY or DONE, state returns to IDLE on the reset edge. Stalls and MulDivBusy are 0 in the next cycle.

Test Plan:
- Forwarding priority: RegWriteM = 1, RdM = 5, RegWriteW = 1, RdW = 5, Rs1E = 5, Rs2E = 0 -> ForwardAE = 10, ForwardBE = 00. Then RegWriteM = 0 -> ForwardAE = 01. Then RdW = 0, Rs1E = 0 -> ForwardAE = 00.
- Load-use: LoadE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for exactly one cycle. RdE = 0 with Rs1D = 0 -> no stall.
- Branch vs load-use: LoadE = 1, RdE = 3, Rs1D = 3, PCSrcE = 1 -> FlushD = FlushE = 1, StallF = StallD = 0.
- Multiply latency: MulDivStartE = 1, MulDivOpE = 0, default params -> stalls and MulDivBusy high for 3 consecutive cycles, then MulDivDone = 1 for 1 cycle, then IDLE. Divide -> 8 stall cycles, then Done. Flipping MulDivOpE mid-BUSY has no effect.
- Back-to-back: second MulDivStartE in the cycle after DONE -> new 3-cycle stall with no gap cycle missed. MulDivStartE held through DONE does not restart.
- Reset mid-divide: assert reset in the 4th BUSY cycle -> next cycle all stalls, MulDivBusy and MulDivDone = 0, state IDLE. A new multiply then completes in 3 stall cycles.
